// File: rtl/arilla_arb_pkg.sv
// Shared types and width helpers for the arilla bus arbiter and its picker.
package arilla_arb_pkg;

  // Two-state arbiter FSM, kept as plain constants for legacy tools.
  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 1'b0;
  localparam arb_state_t ST_OWNED = 1'b1;

  // Width of a master index. At least one bit, even for a single master.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the watchdog counter. It must be able to hold TimeoutCycles.
  function automatic int unsigned wd_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/arilla_arb_picker.sv
// Combinational winner selection. Priority masters override the round-robin
// order. Otherwise the first requester after rr_ptr_i wins.
module arilla_arb_picker
  import arilla_arb_pkg::*;
#(
  parameter int unsigned            NumMasters   = 2,
  parameter logic [NumMasters-1:0]  PriorityMask = '0,
  localparam int unsigned           IdxW         = idx_width(NumMasters)
) (
  input  logic [NumMasters-1:0] req_i,
  input  logic [IdxW-1:0]       rr_ptr_i,
  output logic [IdxW-1:0]       winner_o,
  output logic                  valid_o
);

  logic [NumMasters-1:0] prio;
  logic [IdxW-1:0]       cand;

  // Lowest-index priority requester wins. Otherwise scan from rr_ptr_i+1 onward.
  always_comb begin
    // NOTE: give every always_comb output a default first, so a path that skips the assignment cannot infer a latch.
    prio     = req_i & PriorityMask;
    winner_o = '0;
    cand     = '0;
    if (|prio) begin
      // Scan downward so that the lowest set index is the last one written.
      for (int i = int'(NumMasters) - 1; i >= 0; i--) begin
        if (prio[i]) winner_o = IdxW'(i);
      end
    end else begin
      // Scan offsets from largest to smallest, so the nearest requester after the pointer is the last one written.
      for (int k = int'(NumMasters); k >= 1; k--) begin
        cand = IdxW'((int'(rr_ptr_i) + k) % int'(NumMasters));
        if (req_i[cand]) winner_o = cand;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Arbiter for the shared arilla bus. It issues a registered one-hot grant and
// combines fixed priority with round-robin fairness. It supports lock for
// multi-access sequences. A watchdog reclaims the bus from a hung owner.
module arilla_bus_arbiter
  import arilla_arb_pkg::*;
#(
  parameter int unsigned NumMasters    = 2,
  parameter int unsigned PriorityMask  = 32'b10,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxW         = idx_width(NumMasters)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NumMasters-1:0] req,
  input  logic [NumMasters-1:0] lock,
  input  logic [NumMasters-1:0] done,
  output logic [NumMasters-1:0] gnt,
  output logic [IdxW-1:0]       owner,
  output logic                  busy,
  output logic                  timeout
);

  localparam int unsigned           WdW      = wd_width(TimeoutCycles);
  localparam logic [NumMasters-1:0] PrioMask = PriorityMask[NumMasters-1:0];
  localparam bit                    WdEn     = (TimeoutCycles != 0);
  localparam logic [WdW-1:0]        WdLast   = WdEn ? WdW'(TimeoutCycles - 1) : '0;
  localparam logic [WdW-1:0]        WdMax    = '1;

  arb_state_t            state_q, state_d;
  logic [NumMasters-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic                  timeout_q, timeout_d;
  logic                  rel;

  logic [IdxW-1:0]       pick_winner;
  logic                  pick_valid;

  arilla_arb_picker #(
    .NumMasters  (NumMasters),
    .PriorityMask(PrioMask)
  ) u_picker (
    .req_i   (req),
    .rr_ptr_i(rr_ptr_q),
    .winner_o(pick_winner),
    .valid_o (pick_valid)
  );

  // Next state: grant from IDLE, then hold, extend or release the owner in OWNED.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    rel       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_OWNED;
          gnt_d    = NumMasters'(1) << pick_winner;
          owner_d  = pick_winner;
          rr_ptr_d = pick_winner;
          wd_d     = '0;
        end
      end
      ST_OWNED: begin
        // Only the owner's req/done/lock matter. A done always beats the watchdog.
        if (!req[owner_q] || (done[owner_q] && !lock[owner_q])) begin
          rel = 1'b1;
        end else if (done[owner_q]) begin
          wd_d = '0;
        end else if (WdEn && (wd_q == WdLast)) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else if (wd_q != WdMax) begin
          wd_d = wd_q + WdW'(1);
        end
        // Release always passes through IDLE, which gives one dead cycle between owners.
        if (rel) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= IdxW'(NumMasters - 1);
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == ST_OWNED);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Bench for arilla_bus_arbiter. Two instances share the inputs: one with dm
// priority and one in pure round-robin, both with an 8-cycle watchdog.
module tb_arilla_bus_arbiter;

  localparam int         NM     = 2;
  localparam int         TO     = 8;
  localparam logic [1:0] MASK_A = 2'b10;
  localparam logic [1:0] MASK_B = 2'b00;

  logic       clk;
  logic       rst_n;
  logic [1:0] req, lock, done;
  logic [1:0] gnt_w     [2];
  logic [0:0] owner_w   [2];
  logic       busy_w    [2];
  logic       timeout_w [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, one slot per instance. m_age counts the owned cycles since the grant or the last locked done.
  bit m_busy  [2];
  int m_owner [2];
  int m_rr    [2];
  int m_age   [2];
  bit m_to    [2];

  arilla_bus_arbiter #(.NumMasters(NM), .PriorityMask(32'b10), .TimeoutCycles(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .done(done),
    .gnt(gnt_w[0]), .owner(owner_w[0]), .busy(busy_w[0]), .timeout(timeout_w[0])
  );

  arilla_bus_arbiter #(.NumMasters(NM), .PriorityMask(32'b00), .TimeoutCycles(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .done(done),
    .gnt(gnt_w[1]), .owner(owner_w[1]), .busy(busy_w[1]), .timeout(timeout_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input int i);
    logic [1:0] mask;
    mask = (i == 0) ? MASK_A : MASK_B;
    for (int j = 0; j < NM; j++) if (req[j] && mask[j]) return j;
    for (int k = 1; k <= NM; k++) if (req[(m_rr[i] + k) % NM]) return (m_rr[i] + k) % NM;
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs that are currently applied.
  task automatic model_step();
    int o;
    for (int i = 0; i < 2; i++) begin
      m_to[i] = 1'b0;
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_owner[i] = 0; m_rr[i] = NM - 1; m_age[i] = 0;
      end else if (!m_busy[i]) begin
        if (req != 2'b00) begin
          m_owner[i] = pick(i); m_rr[i] = m_owner[i]; m_busy[i] = 1'b1; m_age[i] = 1;
        end
      end else begin
        o = m_owner[i];
        if (!req[o] || (done[o] && !lock[o])) m_busy[i] = 1'b0;
        else if (done[o]) m_age[i] = 1;
        else if (m_age[i] == TO) begin m_busy[i] = 1'b0; m_to[i] = 1'b1; end
        else m_age[i]++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = 2'b00; lock = 2'b00; done = 2'b00; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b11; lock = 2'b00; done = 2'b00;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (gnt_w[0] !== 2'b00) begin n_errors++; $display("FAIL reset_gnt cyc %0d: got %b want 00", c, gnt_w[0]); end
      n_checks++;
      if (busy_w[0] !== 1'b0) begin n_errors++; $display("FAIL reset_busy cyc %0d: got %b want 0", c, busy_w[0]); end
      n_checks++;
      if (timeout_w[0] !== 1'b0) begin n_errors++; $display("FAIL reset_timeout cyc %0d: got %b want 0", c, timeout_w[0]); end
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (gnt_w[0] !== 2'b10) begin n_errors++; $display("FAIL reset_first_gnt_prio: got %b want 10", gnt_w[0]); end
    n_checks++;
    if (owner_w[0] !== 1'b1) begin n_errors++; $display("FAIL reset_first_owner: got %0d want 1", owner_w[0]); end
    n_checks++;
    if (gnt_w[1] !== 2'b01) begin n_errors++; $display("FAIL reset_first_gnt_rr: got %b want 01", gnt_w[1]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    req = 2'b11;
    tick();
    for (int r = 0; r < 6; r++) begin
      exp = (r % 2 == 0) ? 2'b01 : 2'b10;
      for (int c = 1; c <= 3; c++) begin
        n_checks++;
        if (gnt_w[1] !== exp) begin n_errors++; $display("FAIL rr_gnt round %0d cyc %0d: got %b want %b", r, c, gnt_w[1], exp); end
        if (c == 3) done = exp;
        tick();
        done = 2'b00;
      end
      n_checks++;
      if (gnt_w[1] !== 2'b00) begin n_errors++; $display("FAIL rr_dead round %0d: got %b want 00", r, gnt_w[1]); end
      tick();
    end
  endtask

  task automatic test_lock();
    do_reset();
    req = 2'b01; lock = 2'b01;
    tick();
    req = 2'b11;
    for (int p = 0; p < 3; p++) begin
      done = 2'b01;
      tick();
      done = 2'b00;
      n_checks++;
      if (gnt_w[1] !== 2'b01) begin n_errors++; $display("FAIL lock_hold pulse %0d: got %b want 01", p, gnt_w[1]); end
      n_checks++;
      if (gnt_w[0] !== 2'b01) begin n_errors++; $display("FAIL lock_no_preempt pulse %0d: got %b want 01", p, gnt_w[0]); end
      tick();
    end
    lock = 2'b00; done = 2'b01;
    tick();
    done = 2'b00;
    n_checks++;
    if (gnt_w[1] !== 2'b00) begin n_errors++; $display("FAIL lock_release: got %b want 00", gnt_w[1]); end
    tick();
    n_checks++;
    if (gnt_w[1] !== 2'b10) begin n_errors++; $display("FAIL lock_next_owner: got %b want 10", gnt_w[1]); end
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      req = 2'b01;
      tick();
      for (int c = 1; c <= TO; c++) begin
        n_checks++;
        if (gnt_w[1] !== 2'b01 || timeout_w[1] !== 1'b0) begin
          n_errors++; $display("FAIL to_owned pass %0d cyc %0d: gnt %b to %b want 01/0", pass, c, gnt_w[1], timeout_w[1]);
        end
        if (pass == 1 && c == TO) done = 2'b01;
        tick();
        done = 2'b00;
      end
      n_checks++;
      if (gnt_w[1] !== 2'b00) begin n_errors++; $display("FAIL to_release pass %0d: got %b want 00", pass, gnt_w[1]); end
      n_checks++;
      if (timeout_w[1] !== (pass == 0)) begin n_errors++; $display("FAIL to_pulse pass %0d: got %b want %0d", pass, timeout_w[1], pass == 0); end
      tick();
      n_checks++;
      if (timeout_w[1] !== 1'b0 || gnt_w[1] !== 2'b01) begin
        n_errors++; $display("FAIL to_after pass %0d: to %b gnt %b want 0/01", pass, timeout_w[1], gnt_w[1]);
      end
    end
  endtask

  task automatic test_abandon_reset();
    do_reset();
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    n_checks++;
    if (gnt_w[1] !== 2'b00 || busy_w[1] !== 1'b0) begin n_errors++; $display("FAIL abandon: gnt %b busy %b want 00/0", gnt_w[1], busy_w[1]); end
    req = 2'b01;
    tick();
    n_checks++;
    if (gnt_w[1] !== 2'b01) begin n_errors++; $display("FAIL abandon_regrant: got %b want 01", gnt_w[1]); end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (gnt_w[1] !== 2'b00 || busy_w[1] !== 1'b0 || owner_w[1] !== 1'b0) begin
      n_errors++; $display("FAIL midreset: gnt %b busy %b owner %0d want 00/0/0", gnt_w[1], busy_w[1], owner_w[1]);
    end
    rst_n = 1'b1; req = 2'b11;
    tick();
    n_checks++;
    if (gnt_w[1] !== 2'b01) begin n_errors++; $display("FAIL midreset_rr_ptr: got %b want 01", gnt_w[1]); end
  endtask

  task automatic test_noise();
    do_reset();
    req = 2'b01;
    tick();
    for (int c = 1; c <= TO; c++) begin
      n_checks++;
      if (gnt_w[1] !== 2'b01 || owner_w[1] !== 1'b0 || timeout_w[1] !== 1'b0) begin
        n_errors++; $display("FAIL noise cyc %0d: gnt %b owner %0d to %b want 01/0/0", c, gnt_w[1], owner_w[1], timeout_w[1]);
      end
      if (c < TO) begin done = {c[0], 1'b0}; lock = 2'b10; end
      tick();
      done = 2'b00; lock = 2'b00;
    end
    n_checks++;
    if (gnt_w[1] !== 2'b00 || timeout_w[1] !== 1'b1) begin
      n_errors++; $display("FAIL noise_wd: gnt %b to %b want 00/1", gnt_w[1], timeout_w[1]);
    end
  endtask

  task automatic test_random();
    logic [1:0] eg;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      lock  = 2'($urandom_range(0, 3));
      done  = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        eg = m_busy[i] ? (2'b01 << m_owner[i]) : 2'b00;
        n_checks++;
        if (gnt_w[i] !== eg) begin n_errors++; $display("FAIL rand_gnt inst %0d step %0d: got %b want %b", i, n, gnt_w[i], eg); end
        n_checks++;
        if (busy_w[i] !== m_busy[i]) begin n_errors++; $display("FAIL rand_busy inst %0d step %0d: got %b want %b", i, n, busy_w[i], m_busy[i]); end
        n_checks++;
        if (timeout_w[i] !== m_to[i]) begin n_errors++; $display("FAIL rand_timeout inst %0d step %0d: got %b want %b", i, n, timeout_w[i], m_to[i]); end
        if (m_busy[i]) begin
          n_checks++;
          if (owner_w[i] !== 1'(m_owner[i])) begin n_errors++; $display("FAIL rand_owner inst %0d step %0d: got %0d want %0d", i, n, owner_w[i], m_owner[i]); end
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; lock = 2'b00; done = 2'b00;
    test_reset();
    test_round_robin();
    test_lock();
    test_timeout();
    test_abandon_reset();
    test_noise();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
